// File: rtl/pwm_pkg.sv
// Shared types, constants and the amplitude-to-duty conversion for the multi-channel PWM.
package pwm_pkg;
  localparam int PWM_AMP_W = 8;
  localparam int PWM_CNT_W = 4;
  localparam int PHASE_MAX = (1 << PWM_CNT_W) - 1;

  typedef logic [PWM_CNT_W:0] duty_t;
  typedef logic [PWM_AMP_W+PWM_CNT_W:0] prod_t;

  // Offset-binary rescale of a signed amplitude onto 0..2^CNT_W, rounded to nearest.
  function automatic duty_t amp_to_duty(input logic [PWM_AMP_W-1:0] amp);
    logic [PWM_AMP_W-1:0] u;
    prod_t prod;
    u = amp ^ {1'b1, {(PWM_AMP_W-1){1'b0}}};
    prod = (prod_t'(u) << PWM_CNT_W) + (prod_t'(1) << (PWM_AMP_W - 1));
    return duty_t'(prod >> PWM_AMP_W);
  endfunction
endpackage

// File: rtl/pwm_channel.sv
// One PWM output: active duty register, phase compare and the polarity-adjusted output register.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int   CNT_W = PWM_CNT_W,
  parameter logic POL   = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  duty_t            load_duty,
  input  logic [CNT_W-1:0] phase,
  output logic             pwm_out
);

  duty_t active;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      active <= '0;
    end else if (load) begin
      active <= load_duty;
    end
  end

  // Duty 0 never satisfies the compare and full-scale duty always does, giving constant levels.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pwm_out <= ~POL;
    end else if (!enable) begin
      pwm_out <= ~POL;
    end else begin
      pwm_out <= (duty_t'(phase) < active) ~^ POL;
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM with double-buffered sample intake, period strobe, underrun flag and slow tick.
// AMP_W and CNT_W must match the package widths, since duty_t is fixed there.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int                  CHANNELS = 4,
  parameter int                  AMP_W    = PWM_AMP_W,
  parameter int                  CNT_W    = PWM_CNT_W,
  parameter int                  TICK_DIV = 50000,
  parameter logic [CHANNELS-1:0] POLARITY = {CHANNELS{1'b1}}
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*AMP_W-1:0] in_amp,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic                      period_start,
  output logic                      underrun,
  output logic                      tick_out
);

  localparam int TICK_W = $clog2(TICK_DIV + 1);

  logic [CNT_W-1:0]  phase;
  logic              shadow_full;
  logic              underrun_pend;
  duty_t             shadow [CHANNELS];
  logic [TICK_W-1:0] tick_cnt;
  logic              boundary;
  logic              transfer;
  logic              load;

  assign in_ready = ~shadow_full;
  assign transfer = in_valid && in_ready;
  assign boundary = enable && (phase == CNT_W'(PHASE_MAX));
  assign load     = boundary && shadow_full;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase <= '0;
    end else if (!enable) begin
      phase <= '0;
    end else begin
      phase <= phase + 1'b1;
    end
  end

  // Transfer and load never coincide: a transfer needs an empty shadow, a load a full one.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shadow_full <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) shadow[c] <= '0;
    end else begin
      if (load) begin
        shadow_full <= 1'b0;
      end else if (transfer) begin
        shadow_full <= 1'b1;
      end
      if (transfer) begin
        for (int c = 0; c < CHANNELS; c++) shadow[c] <= amp_to_duty(in_amp[c*AMP_W +: AMP_W]);
      end
    end
  end

  // An empty-shadow boundary is remembered until the first enabled phase-0 cycle so that
  // underrun lines up with period_start even if enable drops right after the boundary.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      period_start  <= 1'b0;
      underrun      <= 1'b0;
      underrun_pend <= 1'b0;
    end else begin
      period_start <= (phase == '0) && enable;
      underrun     <= underrun_pend && (phase == '0) && enable;
      if (boundary && !shadow_full) begin
        underrun_pend <= 1'b1;
      end else if ((phase == '0) && enable) begin
        underrun_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
      tick_out <= 1'b0;
    end else if (boundary) begin
      if (tick_cnt == TICK_W'(TICK_DIV - 1)) begin
        tick_cnt <= '0;
        tick_out <= ~tick_out;
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    pwm_channel #(
      .CNT_W (CNT_W),
      .POL   (POLARITY[c])
    ) u_chan (
      .clock     (clock),
      .reset     (reset),
      .enable    (enable),
      .load      (load),
      .load_duty (shadow[c]),
      .phase     (phase),
      .pwm_out   (pwm_out[c])
    );
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi: directed steps plus random traffic against a behavioural model.
module tb_pwm_multi;

  localparam int         CH       = 4;
  localparam int         AMP_W    = 8;
  localparam int         CNT_W    = 4;
  localparam int         TICK_DIV = 3;
  localparam int         PERIOD   = 1 << CNT_W;
  localparam logic [3:0] POL      = 4'b0101;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_amp;
  logic [3:0]  pwm_out;
  logic        period_start;
  logic        underrun;
  logic        tick_out;

  int checks = 0;
  int passed = 0;

  // Behavioural model state
  int         m_phase;
  int         m_active [CH];
  int         m_shadow [CH];
  bit         m_full;
  bit         m_urpend;
  int         m_periods;
  logic [3:0] exp_pwm;
  logic       exp_ps;
  logic       exp_ur;
  logic       exp_tick;

  bit         seen;
  int         n;
  logic       last_tick;
  logic [3:0] inactive;

  pwm_multi #(
    .CHANNELS (CH),
    .AMP_W    (AMP_W),
    .CNT_W    (CNT_W),
    .TICK_DIV (TICK_DIV),
    .POLARITY (POL)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_amp       (in_amp),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .underrun     (underrun),
    .tick_out     (tick_out)
  );

  always #5 clock = ~clock;

  function automatic int duty_ref(int amp);
    return ((amp + 128) * PERIOD + 128) / 256;
  endfunction

  task automatic check_val(string tag, logic [31:0] observed, logic [31:0] expected);
    checks++;
    assert (observed === expected) passed++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  task automatic model_reset();
    m_phase   = 0;
    m_full    = 0;
    m_urpend  = 0;
    m_periods = 0;
    for (int c = 0; c < CH; c++) begin
      m_active[c] = 0;
      m_shadow[c] = 0;
    end
    exp_pwm  = ~POL;
    exp_ps   = 1'b0;
    exp_ur   = 1'b0;
    exp_tick = 1'b0;
  endtask

  // Advance the model by one clock using the inputs presented for this edge.
  task automatic step_model();
    bit boundary;
    bit xfer;
    bit first_cycle;
    boundary    = enable && (m_phase == PERIOD - 1);
    xfer        = in_valid && !m_full;
    first_cycle = enable && (m_phase == 0);
    for (int c = 0; c < CH; c++)
      exp_pwm[c] = enable ? ((m_phase < m_active[c]) == POL[c]) : ~POL[c];
    exp_ps = first_cycle;
    exp_ur = first_cycle && m_urpend;
    if (first_cycle) m_urpend = 0;
    if (boundary) begin
      if (m_full) begin
        for (int c = 0; c < CH; c++) m_active[c] = m_shadow[c];
        m_full = 0;
      end else begin
        m_urpend = 1;
      end
      m_periods++;
      if (m_periods == TICK_DIV) begin
        m_periods = 0;
        exp_tick  = ~exp_tick;
      end
    end
    if (xfer) begin
      for (int c = 0; c < CH; c++) begin
        int a;
        a = $signed(in_amp[c*AMP_W +: AMP_W]);
        m_shadow[c] = duty_ref(a);
      end
      m_full = 1;
    end
    m_phase = enable ? (m_phase + 1) % PERIOD : 0;
  endtask

  task automatic checkOutput(string tag);
    check_val({tag, "_in_ready"}, in_ready, !m_full);
    check_val({tag, "_pwm_out"}, pwm_out, exp_pwm);
    check_val({tag, "_period_start"}, period_start, exp_ps);
    check_val({tag, "_underrun"}, underrun, exp_ur);
    check_val({tag, "_tick_out"}, tick_out, exp_tick);
  endtask

  task automatic applyStimulus(logic valid, logic en, logic [31:0] amps);
    in_valid = valid;
    enable   = en;
    in_amp   = amps;
  endtask

  task automatic step(string tag);
    @(posedge clock);
    step_model();
    #1;
    checkOutput(tag);
  endtask

  // Load one sample set, wait for it to go live, then count high cycles per channel over a period.
  task automatic load_measure(string tag, logic [31:0] amps, int e0, int e1, int e2, int e3);
    int  cnt [CH];
    int  want [CH];
    bit  ok;
    want = '{e0, e1, e2, e3};
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) if (in_ready) ok = 1; else step(tag);
    check_val({tag, "_ready_before"}, ok, 1);
    applyStimulus(1'b1, 1'b1, amps);
    step(tag);
    applyStimulus(1'b0, 1'b1, '0);
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) if (in_ready) ok = 1; else step(tag);
    check_val({tag, "_ready_after"}, ok, 1);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) if (period_start) ok = 1; else step(tag);
    check_val({tag, "_period_seen"}, ok, 1);
    for (int c = 0; c < CH; c++) cnt[c] = 0;
    for (int i = 0; i < PERIOD; i++) begin
      if (i > 0) step(tag);
      for (int c = 0; c < CH; c++) cnt[c] += int'(pwm_out[c]);
    end
    for (int c = 0; c < CH; c++)
      check_val($sformatf("%s_high_ch%0d", tag, c), cnt[c], want[c]);
  endtask

  initial begin
    inactive = ~POL;
    reset    = 1'b1;
    applyStimulus(1'b0, 1'b1, '0);
    model_reset();
    #12;
    checkOutput("reset");
    @(negedge clock);
    reset = 1'b0;

    $display("[TB] idle periods");
    n = 0;
    for (int i = 0; i < 3 * PERIOD; i++) begin
      step("idle");
      if (period_start) n++;
    end
    check_val("idle_strobe_count", n, 3);

    $display("[TB] mixed amplitudes and uniform zero");
    load_measure("load_mixed", 32'h7F40_0080, 0, 8, 12, 0);
    load_measure("load_zero", 32'h0000_0000, 8, 8, 8, 8);

    $display("[TB] transfer on boundary cycle");
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++)
      if (m_phase == PERIOD - 1 && !m_full) seen = 1; else step("pre_boundary");
    check_val("boundary_reached", seen, 1);
    applyStimulus(1'b1, 1'b1, $urandom());
    step("boundary_xfer");
    applyStimulus(1'b0, 1'b1, '0);
    seen = 0;
    for (int i = 0; i < 4 && !seen; i++) if (period_start) seen = 1; else step("boundary_wait");
    check_val("boundary_strobe_seen", seen, 1);
    check_val("boundary_underrun", underrun, 1);
    check_val("boundary_ready_low", in_ready, 0);
    repeat (2 * PERIOD) step("after_boundary");

    $display("[TB] tick period and enable hold");
    last_tick = tick_out;
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      step("tick_sync");
      if (tick_out !== last_tick) seen = 1;
    end
    check_val("tick_sync_seen", seen, 1);
    last_tick = tick_out;
    n = 0;
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      step("tick_run");
      n++;
      if (tick_out !== last_tick) seen = 1;
    end
    check_val("tick_run_seen", seen, 1);
    check_val("tick_period", n, 3 * PERIOD);
    last_tick = tick_out;
    n = 0;
    applyStimulus(1'b0, 1'b0, '0);
    repeat (20) begin
      step("disabled");
      n++;
      check_val("disabled_pwm_inactive", pwm_out, inactive);
    end
    applyStimulus(1'b0, 1'b1, '0);
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      step("tick_resume");
      n++;
      if (tick_out !== last_tick) seen = 1;
    end
    check_val("tick_resume_seen", seen, 1);
    check_val("tick_delayed", n, 3 * PERIOD + 20);

    $display("[TB] random traffic");
    repeat (250) begin
      applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 15) != 0, $urandom());
      step("random");
    end
    applyStimulus(1'b0, 1'b1, '0);

    $display("[TB] reset mid-period with shadow full");
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++)
      if (m_phase == 0 && !m_full) seen = 1; else step("pre_reset");
    check_val("pre_reset_aligned", seen, 1);
    applyStimulus(1'b1, 1'b1, 32'h40C0_7F20);
    step("pre_reset_load");
    applyStimulus(1'b0, 1'b1, '0);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++)
      if (m_phase == 7 && m_full) seen = 1; else step("pre_reset_wait");
    check_val("pre_reset_phase7", seen, 1);
    #1 reset = 1'b1;
    #1 model_reset();
    checkOutput("async_reset");
    @(negedge clock);
    reset = 1'b0;
    repeat (2 * PERIOD) begin
      step("post_reset");
      check_val("post_reset_pwm_inactive", pwm_out, inactive);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
- Multi-channel, parametrised pulse-width modulator for the BPSK transmit path.
- Accepts signed amplitude samples via a valid/ready handshake and double-buffers them.
- New duties apply only at period boundaries, so pulses never glitch mid-period.
- Generates a shared period strobe, a slow divided "human-visible" tick and an underrun flag for the upstream sample source.

Parameters:
- CHANNELS, 4, number of independent PWM outputs.
- AMP_W, 8, width of each signed two's-complement amplitude sample.
- CNT_W, 4, phase counter width; PWM period = 2^CNT_W clocks.
- TICK_DIV, 50000, number of PWM periods per half-cycle of tick_out.
- POLARITY, {CHANNELS{1'b1}}, per-channel bit: 1 = active-high pulse, 0 = active-low.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  run/hold control for the phase counter and outputs.
- in_valid  in  1  sample bus holds a new set of samples.
- in_ready  out  1  shadow buffer empty; a sample set can be accepted.
- in_amp  in  CHANNELS*AMP_W  packed signed samples; channel 0 in LSBs.
- pwm_out  out  CHANNELS  registered PWM pulses.
- period_start  out  1  one-cycle strobe on the first cycle of each period.
- underrun  out  1  one-cycle pulse when a period starts with no new sample.
- tick_out  out  1  slow square wave.

Behaviour:
- Reset (async, immediate):
  - phase=0; active duties=0; shadow empty, so in_ready=1.
  - pwm_out[c]=~POLARITY[c] (inactive level).
  - period_start=0, underrun=0, tick_out=0, tick counter=0.
- Duty conversion, per channel, on accept:
  - u = amp + 2^(AMP_W-1), unsigned, range 0..2^AMP_W-1.
  - duty = (u*2^CNT_W + 2^(AMP_W-1)) >> AMP_W, width CNT_W+1, range 0..2^CNT_W.
  - Intermediate product is AMP_W+CNT_W+1 bits; no overflow.
  - Defaults: amp -128 -> 0, 0 -> 8, +127 -> 16.
- Handshake:
  - Transfer occurs when in_valid && in_ready. Duties are written to the shadow register and in_ready drops the next cycle.
  - in_ready is a direct register output (!shadow_full), with no combinational path from in_valid.
  - in_amp is sampled only on a transfer.
- Phase counter:
  - With enable=1, phase increments by 1 each clock and wraps from 2^CNT_W-1 to 0.
  - A boundary is the cycle in which phase==2^CNT_W-1 and enable=1.
- At a boundary, shadow full:
  - active <= shadow; shadow emptied; in_ready=1 from the next cycle.
- At a boundary, shadow empty:
  - Active duties hold; underrun pulses for 1 cycle, coincident with the next period_start.
- Simultaneous transfer and boundary:
  - The shadow state before the transfer decides the boundary, so underrun fires.
  - The accepted sample becomes active at the following boundary.
- Outputs:
  - pwm_out[c] <= (phase < active[c]) XNOR POLARITY[c], registered: 1 clock latency from phase.
  - duty 0 gives a constant inactive level; duty 2^CNT_W gives a constant active level.
  - period_start <= (phase==0 && enable), registered, same alignment as pwm_out.
- Tick:
  - A period counter increments at each boundary.
  - At boundary number TICK_DIV, the counter clears and tick_out toggles.
  - tick_out period = 2*TICK_DIV*2^CNT_W clocks.
- enable=0:
  - phase forced to 0; pwm_out at inactive level; period_start=0; tick counter holds.
  - The handshake still accepts into the shadow.
  - On re-enable, the first period uses the existing active duties; the first boundary then loads the shadow.
- Reset mid-period: all state returns to reset values immediately and any pending shadow sample is discarded.

Decomposition:
- Package pwm_pkg holds:
  - the duty_t typedef (CNT_W+1 bits);
  - the function amp_to_duty(amp), containing the formula above;
  - the constant PHASE_MAX.
- One sub-module, pwm_channel, per channel generated CHANNELS times. It holds the active duty register, the compare and the polarity register.
- Phase counter, shadow buffer, handshake and tick divider stay in pwm_multi.

Test Plan:
1. Reset then run, in_valid=0 -> all pwm_out inactive; period_start every 16 clocks; underrun pulses with each period_start; in_ready=1.
2. Load amps {-128,0,64,127} -> from the next boundary, channel high counts per 16-clock period are {0,8,12,16}; in_ready low until that boundary.
3. Transfer on the boundary cycle with shadow empty -> underrun=1 that period; new duties appear one period later.
4. POLARITY=4'b0101, amp 0 on all channels -> channels 1 and 3 low for 8 clocks per period; channels 0 and 2 high for 8 clocks.
5. TICK_DIV=3 -> tick_out toggles every 48 clocks; deassert enable for 20 clocks -> tick toggle delayed by 20 clocks, outputs inactive meanwhile.
6. Assert reset at phase 7 with shadow full -> immediately outputs inactive and in_ready=1; after release, duties read 0 until a new load.
